gamepad_event_queue: RTL and testbench
======================================

Name: gamepad_event_queue

Overview:
- Sits between the gamepad reader and the robot controller in the Clock50 domain.
- Takes the 12-bit button vector from the gamepad reader and samples it once per video frame on v_sync.
- Debounces each button over several frames and turns each debounced press (0→1) into a button-index event.
- Buffers the events in a small FIFO. The controller pops them with a valid/ready handshake, so each press moves the robot exactly one step.

Parameters:
- BTN_W, 12: number of button lines; event codes are 0..BTN_W-1.
- DEBOUNCE_FRAMES, 3: consecutive differing frame samples needed to flip a stable button; legal range 1..7.
- FIFO_DEPTH, 8: event FIFO entries; must be a power of two.

Ports:
- Clock50, input, 1: system clock, 50 MHz.
- Reset, input, 1: asynchronous, active-low reset.
- v_sync, input, 1: vertical sync from the VGA interface, active low, asynchronous to Clock50.
- Buttons, input, BTN_W: raw button state from the gamepad reader; 1 = pressed.
- evt_ready, input, 1: the consumer accepts the head event this cycle.
- evt_valid, output, 1: the FIFO is non-empty.
- evt_code, output, 4: button index at the FIFO head.
- evt_count, output, 4: FIFO occupancy, 0..FIFO_DEPTH.
- stable_buttons, output, BTN_W: debounced button levels.
- overflow, output, 1: sticky flag; at least one event was dropped because the FIFO was full.

Behaviour:
- Reset, when Reset = 0:
  - All outputs are 0, per-button counters 0, pending mask 0, FIFO pointers 0.
  - Both v_sync synchroniser flops and the edge-history flop reset to 1, so no spurious tick occurs after reset.
- Frame tick:
  - v_sync passes through two flops, giving vs_s. A history flop holds vs_d.
  - tick = vs_d & ~vs_s, a single-cycle pulse on each falling edge of v_sync.
  - tick is high in the 3rd rising edge after v_sync is first sampled low.
  - A low pulse on v_sync shorter than 2 clocks may be missed; this is acceptable.
- Debounce, evaluated on the tick cycle only, for each button i:
  - If Buttons[i] == stable_buttons[i]: cnt[i] ← 0.
  - Otherwise, if cnt[i] == DEBOUNCE_FRAMES-1: stable_buttons[i] toggles and cnt[i] ← 0.
  - Otherwise: cnt[i] increments.
  - Result: a level change must persist for DEBOUNCE_FRAMES consecutive ticks before it is accepted. With DEBOUNCE_FRAMES = 1, stable_buttons follows Buttons on every tick.
- Press detection:
  - Registered at the end of the cycle after the tick: pending ← pending | (stable_buttons & ~stable_prev).
  - stable_prev is then updated.
  - Releases generate no event.
- Scanner:
  - Each cycle with pending ≠ 0, take the lowest set index j and attempt a push of code j, then clear pending[j].
  - One event is pushed per cycle, so 12 simultaneous presses take 12 cycles.
  - Presses from a new tick OR into any pending bits still outstanding; no pending press is lost.
- FIFO:
  - pop = evt_valid & evt_ready.
  - A push is accepted if evt_count < FIFO_DEPTH, or if evt_count == FIFO_DEPTH and pop is high in the same cycle.
  - If a push is rejected, the event is discarded, pending[j] is still cleared, and overflow ← 1.
  - overflow is cleared only by reset.
  - evt_count: +1 on push only, -1 on pop only, unchanged on push and pop together. It never exceeds FIFO_DEPTH and never underflows.
  - evt_ready while evt_valid = 0 is ignored.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- Outputs:
  - evt_valid = (evt_count ≠ 0).
  - evt_code is the registered head entry, valid whenever evt_valid = 1. Its value is don't-care when the FIFO is empty; the implementation drives 0.
  - evt_code holds stable until popped.
- Latency: with an empty FIFO, a newly debounced press gives evt_valid = 1 exactly 3 cycles after the tick cycle.
  - Tick cycle: stable updated.
  - +1: pending updated.
  - +2: push.
  - +3: evt_valid high.
- Mid-operation reset: the FIFO and all pending events are lost immediately. After release, the first tick debounces from stable_buttons = 0.

Test Plan:
1. Reset = 0, then 1; v_sync held high for 100 cycles → no tick; evt_valid = 0; stable_buttons = 0x000; overflow = 0.
2. DEBOUNCE_FRAMES = 3; Buttons = 0x004 held over ticks 1–3 → stable_buttons = 0x004 after tick 3. evt_valid rises 3 cycles after tick 3 with evt_code = 2. Pop → evt_count = 0. Holding the button gives no further events.
3. Buttons = 0x004 for 2 ticks, then 0x000 on tick 3 → stable_buttons stays 0, no event. This is the bounce-rejection check.
4. Buttons = 0x811 stable for 3 ticks, evt_ready = 0 → FIFO holds codes 0, 4, 11 in that order, pushed on consecutive cycles; evt_count = 3.
5. With evt_ready = 0, generate 9 distinct press events → evt_count = 8 and overflow = 1. The first 8 codes are preserved; popping all 8 returns them in order.
6. FIFO full (8 entries) with evt_ready = 1 on the same cycle a push arrives → push accepted, evt_count stays 8, overflow unchanged. Also: Reset pulsed low mid-scan → all outputs 0 in the same cycle (asynchronous clear).

Source files
------------

// File: rtl/gamepad_event_queue.sv
// Gamepad front end: per-frame debounce of the button vector, press-to-event
// conversion and a small event FIFO drained with a valid/ready handshake.
module gamepad_event_queue #(
   parameter int BTN_W           = 12,
   parameter int DEBOUNCE_FRAMES = 3,
   parameter int FIFO_DEPTH      = 8
) (
   input  logic             Clock50,
   input  logic             Reset,
   input  logic             v_sync,
   input  logic [BTN_W-1:0] Buttons,
   input  logic             evt_ready,
   output logic             evt_valid,
   output logic [3:0]       evt_code,
   output logic [3:0]       evt_count,
   output logic [BTN_W-1:0] stable_buttons,
   output logic             overflow
);

   localparam int         PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [3:0] DEPTH_C = 4'(FIFO_DEPTH);
   localparam logic [2:0] DB_MAX  = 3'(DEBOUNCE_FRAMES - 1);

   logic             r_vs1, r_vs2, r_vs_d;
   logic             w_tick;
   logic [2:0]       r_cnt [BTN_W];
   logic [BTN_W-1:0] r_stable, r_prev, r_pend;
   logic [BTN_W-1:0] w_clr;
   logic [3:0]       w_idx;
   logic [3:0]       r_mem [FIFO_DEPTH];
   logic [PW-1:0]    r_wr, r_rd;
   logic [3:0]       r_count;
   logic             r_ovf;
   logic             w_pop, w_push_req, w_push;

   // Flops reset high so releasing reset with v_sync high cannot fake an edge.
   always_ff @(posedge Clock50 or negedge Reset) begin
      if (!Reset) begin
         r_vs1  <= 1'b1;
         r_vs2  <= 1'b1;
         r_vs_d <= 1'b1;
      end else begin
         r_vs1  <= v_sync;
         r_vs2  <= r_vs1;
         r_vs_d <= r_vs2;
      end
   end

   assign w_tick = r_vs_d & ~r_vs2;

   always_ff @(posedge Clock50 or negedge Reset) begin
      if (!Reset) begin
         for (int i = 0; i < BTN_W; i++) r_cnt[i] <= '0;
         r_stable <= '0;
      end else if (w_tick) begin
         for (int i = 0; i < BTN_W; i++) begin
            if (Buttons[i] == r_stable[i]) begin
               r_cnt[i] <= '0;
            end else if (r_cnt[i] == DB_MAX) begin
               r_stable[i] <= ~r_stable[i];
               r_cnt[i]    <= '0;
            end else begin
               r_cnt[i] <= r_cnt[i] + 3'd1;
            end
         end
      end
   end

   // Lowest pending bit is isolated by two's-complement masking.
   assign w_clr = r_pend & (~r_pend + {{(BTN_W-1){1'b0}}, 1'b1});

   always_comb begin
      w_idx = '0;
      for (int i = BTN_W - 1; i >= 0; i--) begin
         if (r_pend[i]) w_idx = 4'(i);
      end
   end

   always_ff @(posedge Clock50 or negedge Reset) begin
      if (!Reset) begin
         r_prev <= '0;
         r_pend <= '0;
      end else begin
         r_prev <= r_stable;
         r_pend <= (r_pend & ~w_clr) | (r_stable & ~r_prev);
      end
   end

   assign w_pop      = evt_valid & evt_ready;
   assign w_push_req = |r_pend;
   assign w_push     = w_push_req & ((r_count != DEPTH_C) | w_pop);

   always_ff @(posedge Clock50) begin
      if (w_push) r_mem[r_wr] <= w_idx;
   end

   always_ff @(posedge Clock50 or negedge Reset) begin
      if (!Reset) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
      end else begin
         if (w_push) r_wr <= r_wr + PW'(1);
         if (w_pop)  r_rd <= r_rd + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 4'd1;
            2'b01:   r_count <= r_count - 4'd1;
            default: r_count <= r_count;
         endcase
         if (w_push_req && !w_push) r_ovf <= 1'b1;
      end
   end

   assign evt_valid      = (r_count != 4'd0);
   assign evt_code       = evt_valid ? r_mem[r_rd] : 4'd0;
   assign evt_count      = r_count;
   assign stable_buttons = r_stable;
   assign overflow       = r_ovf;

endmodule

// File: tb/tb_gamepad_event_queue.sv
// Directed bench for gamepad_event_queue: a frame-level queue model checked
// every cycle, plus hand-computed expectations at key points.
module tb_gamepad_event_queue;

   logic        Clock50 = 1'b0;
   logic        Reset = 1'b0;
   logic        v_sync = 1'b1;
   logic [11:0] Buttons = 12'h000;
   logic        evt_ready = 1'b0;
   logic        evt_valid;
   logic [3:0]  evt_code;
   logic [3:0]  evt_count;
   logic [11:0] stable_buttons;
   logic        overflow;

   int checks = 0;
   int errors = 0;

   gamepad_event_queue dut (
      .Clock50(Clock50), .Reset(Reset), .v_sync(v_sync), .Buttons(Buttons),
      .evt_ready(evt_ready), .evt_valid(evt_valid), .evt_code(evt_code),
      .evt_count(evt_count), .stable_buttons(stable_buttons), .overflow(overflow)
   );

   always #10 Clock50 = ~Clock50;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Model: v_sync history, debounce counters, pending set, event queue.
   int          mcnt [12];
   logic [11:0] mstable, mpend, mrise, mold;
   int          q[$];
   bit          movf, a1, a2, a3, tick;
   int          j;

   always @(posedge Clock50 or negedge Reset) begin
      if (!Reset) begin
         for (int i = 0; i < 12; i++) mcnt[i] = 0;
         mstable = '0; mpend = '0; mrise = '0; movf = 0;
         q.delete();
         a1 = 1; a2 = 1; a3 = 1;
      end else begin
         tick = a3 & ~a2;
         a3 = a2; a2 = a1; a1 = v_sync;
         if (q.size() != 0 && evt_ready) void'(q.pop_front());
         if (mpend != 0) begin
            j = 0;
            for (int i = 11; i >= 0; i--) if (mpend[i]) j = i;
            if (q.size() < 8) q.push_back(j);
            else movf = 1;
            mpend[j] = 1'b0;
         end
         mpend = mpend | mrise;
         mrise = '0;
         if (tick) begin
            mold = mstable;
            for (int i = 0; i < 12; i++) begin
               if (Buttons[i] == mstable[i]) mcnt[i] = 0;
               else if (mcnt[i] == 2) begin mstable[i] = ~mstable[i]; mcnt[i] = 0; end
               else mcnt[i] = mcnt[i] + 1;
            end
            mrise = mstable & ~mold;
         end
      end
   end

   always @(negedge Clock50) begin
      if (Reset) begin
         chk("m_valid", evt_valid, q.size() != 0);
         chk("m_count", evt_count, q.size());
         chk("m_code", evt_code, (q.size() != 0) ? q[0] : 0);
         chk("m_stable", stable_buttons, mstable);
         chk("m_ovf", overflow, movf);
      end
   end

   task automatic frame();
      v_sync = 1'b0;
      repeat (4) @(negedge Clock50);
      v_sync = 1'b1;
      repeat (4) @(negedge Clock50);
   endtask

   task automatic frames(input int n);
      for (int k = 0; k < n; k++) frame();
   endtask

   task automatic pop_expect(input string name, input int first, input int n, input int step);
      for (int k = 0; k < n; k++) begin
         chk(name, evt_code, first + k * step);
         evt_ready = 1'b1;
         @(negedge Clock50);
      end
      evt_ready = 1'b0;
   endtask

   initial begin
      int exp4[3];
      exp4 = '{0, 4, 11};
      repeat (3) @(negedge Clock50);
      Reset = 1'b1;
      repeat (100) @(negedge Clock50);
      chk("rst_valid", evt_valid, 0);
      chk("rst_stable", stable_buttons, 12'h000);
      chk("rst_ovf", overflow, 0);
      chk("rst_count", evt_count, 0);

      // single press, latency, pop, hold
      Buttons = 12'h004;
      frames(2);
      chk("db_not_yet", stable_buttons, 12'h000);
      v_sync = 1'b0;
      repeat (4) @(negedge Clock50);
      chk("lat_pre", evt_valid, 0);
      @(negedge Clock50);
      chk("lat_valid", evt_valid, 1);
      chk("lat_code", evt_code, 2);
      chk("lat_stable", stable_buttons, 12'h004);
      v_sync = 1'b1;
      repeat (3) @(negedge Clock50);
      evt_ready = 1'b1;
      @(negedge Clock50);
      evt_ready = 1'b0;
      chk("pop_count", evt_count, 0);
      frames(3);
      chk("hold_no_evt", evt_count, 0);
      Buttons = 12'h000;
      frames(3);
      chk("release_stable", stable_buttons, 12'h000);
      chk("release_no_evt", evt_count, 0);

      // bounce rejection
      Buttons = 12'h004;
      frames(2);
      Buttons = 12'h000;
      frames(2);
      chk("bounce_stable", stable_buttons, 12'h000);
      chk("bounce_count", evt_count, 0);

      // three simultaneous presses
      Buttons = 12'h811;
      frames(3);
      chk("multi_count", evt_count, 3);
      chk("multi_stable", stable_buttons, 12'h811);
      for (int k = 0; k < 3; k++) begin
         chk("multi_order", evt_code, exp4[k]);
         evt_ready = 1'b1;
         @(negedge Clock50);
      end
      evt_ready = 1'b0;
      chk("multi_empty", evt_count, 0);
      Buttons = 12'h000;
      frames(3);

      // overflow: nine presses into eight slots
      Buttons = 12'h1FF;
      frames(3);
      repeat (8) @(negedge Clock50);
      chk("ovf_count", evt_count, 8);
      chk("ovf_flag", overflow, 1);
      pop_expect("ovf_order", 0, 8, 1);
      chk("ovf_empty", evt_count, 0);
      chk("ovf_sticky", overflow, 1);

      // full FIFO with simultaneous pop and push
      Reset = 1'b0;
      @(negedge Clock50);
      Reset = 1'b1;
      chk("rst2_ovf", overflow, 0);
      frames(2);
      v_sync = 1'b0;
      repeat (12) @(negedge Clock50);
      chk("full_count", evt_count, 8);
      evt_ready = 1'b1;
      @(negedge Clock50);
      evt_ready = 1'b0;
      chk("pp_count", evt_count, 8);
      chk("pp_ovf", overflow, 0);
      chk("pp_head", evt_code, 1);
      v_sync = 1'b1;
      repeat (4) @(negedge Clock50);
      pop_expect("pp_order", 1, 8, 1);
      chk("pp_empty", evt_count, 0);

      // reset asserted mid-scan
      Buttons = 12'hFFF;
      frames(2);
      v_sync = 1'b0;
      repeat (5) @(negedge Clock50);
      chk("scan_count", evt_count, 1);
      chk("scan_code", evt_code, 9);
      #1 Reset = 1'b0;
      #1;
      chk("arst_valid", evt_valid, 0);
      chk("arst_count", evt_count, 0);
      chk("arst_code", evt_code, 0);
      chk("arst_stable", stable_buttons, 12'h000);
      chk("arst_ovf", overflow, 0);
      @(negedge Clock50);
      Reset = 1'b1;
      v_sync = 1'b1;
      repeat (10) @(negedge Clock50);
      chk("post_rst_count", evt_count, 0);
      chk("post_rst_stable", stable_buttons, 12'h000);
      frames(3);
      repeat (10) @(negedge Clock50);
      chk("redb_stable", stable_buttons, 12'hFFF);
      chk("redb_count", evt_count, 8);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
